// File: rtl/cnn_pkg.sv
// cnn_pkg: image geometry and window-generator state type shared by
// the cnn_window_gen block and its line buffers.
package cnn_pkg;

    localparam int IMG_W   = 28;
    localparam int IMG_H   = 28;
    localparam int K       = 3;
    localparam int OUT_W   = IMG_W - K + 1;
    localparam int NUM_WIN = OUT_W * OUT_W;

    typedef enum logic [1:0] {
        FILL,
        RUN,
        DONE
    } win_state_t;

endpackage

// File: rtl/cnn_line_fifo.sv
// cnn_line_fifo: 1-bit delay line of DEPTH stages, advancing only on en.
// dout is the bit that was pushed DEPTH enabled cycles ago.
module cnn_line_fifo #(
    parameter int DEPTH = 28
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] sr_q;
    logic [DEPTH-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (en) begin
            sr_d = {sr_q[DEPTH-2:0], din};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/cnn_window_gen.sv
// cnn_window_gen: streams a raster bit image and emits every 3x3 window.
// Optional win_row/win_col outputs are built when CNN_WIN_IDX_EN is defined.
module cnn_window_gen #(
    parameter int IMG_W = cnn_pkg::IMG_W,
    parameter int IMG_H = cnn_pkg::IMG_H,
    parameter int K     = cnn_pkg::K
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       pix_vld,
    input  logic       pix,
    output logic       pix_rdy,
    output logic       win_vld,
    output logic [8:0] win,
    input  logic       win_rdy,
    output logic       frame_done
`ifdef CNN_WIN_IDX_EN
    ,
    output logic [4:0] win_row,
    output logic [4:0] win_col
`endif
);

    import cnn_pkg::*;

    localparam logic [4:0] COL_MAX  = 5'(IMG_W - 1);
    localparam logic [4:0] ROW_MAX  = 5'(IMG_H - 1);
    localparam logic [9:0] WIN_LAST =
        10'((IMG_W - K + 1) * (IMG_H - K + 1) - 1);

    if (K != 3) begin : g_k_check
        $error("cnn_window_gen: only K=3 is supported");
    end

    win_state_t state_q;
    win_state_t state_d;
    logic [4:0] col_q;
    logic [4:0] col_d;
    logic [4:0] row_q;
    logic [4:0] row_d;
    logic [9:0] win_cnt_q;
    logic [9:0] win_cnt_d;
    logic       win_vld_q;
    logic       win_vld_d;
    logic [8:0] win_q;
    logic [8:0] win_d;
    logic       frame_done_q;
    logic       frame_done_d;
    logic       rdy_en_q;
    logic       rdy_en_d;

    logic pix_xfer;
    logic win_xfer;
    logic emit;
    logic l0_out;
    logic l1_out;

    // rdy_en_q holds pix_rdy low for the first cycle out of reset.
    assign rdy_en_d = 1'b1;
    assign pix_rdy  = rdy_en_q && (state_q != DONE)
                      && (!win_vld_q || win_rdy);
    assign pix_xfer = pix_vld && pix_rdy && !clr;
    assign win_xfer = win_vld_q && win_rdy && !clr;
    assign emit     = pix_xfer && (row_q >= 5'd2) && (col_q >= 5'd2);

    cnn_line_fifo #(
        .DEPTH(IMG_W)
    ) u_line0 (
        .clk (clk),
        .rst (rst),
        .en  (pix_xfer),
        .din (pix),
        .dout(l0_out)
    );

    cnn_line_fifo #(
        .DEPTH(IMG_W)
    ) u_line1 (
        .clk (clk),
        .rst (rst),
        .en  (pix_xfer),
        .din (l0_out),
        .dout(l1_out)
    );

    // Each window row is 3 bits, oldest column in the low bit.
    always_comb begin
        col_d     = col_q;
        row_d     = row_q;
        win_cnt_d = win_cnt_q;
        win_vld_d = win_vld_q;
        win_d     = win_q;
        if (pix_xfer) begin
            win_d = {pix,    win_q[8:7],
                     l0_out, win_q[5:4],
                     l1_out, win_q[2:1]};
            if (col_q == COL_MAX) begin
                col_d = '0;
                row_d = (row_q == ROW_MAX) ? 5'd0 : row_q + 5'd1;
            end else begin
                col_d = col_q + 5'd1;
            end
        end
        if (win_xfer) begin
            win_cnt_d = win_cnt_q + 10'd1;
            win_vld_d = 1'b0;
        end
        if (emit) begin
            win_vld_d = 1'b1;
        end
        if (clr) begin
            col_d     = '0;
            row_d     = '0;
            win_cnt_d = '0;
            win_vld_d = 1'b0;
        end
    end

    always_comb begin
        state_d      = state_q;
        frame_done_d = 1'b0;
        unique case (state_q)
            FILL: begin
                if (pix_xfer && row_q == 5'd1 && col_q == COL_MAX) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (win_xfer && win_cnt_q == WIN_LAST) begin
                    state_d      = DONE;
                    frame_done_d = 1'b1;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = FILL;
            end
        endcase
        if (clr) begin
            state_d = FILL;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= FILL;
            col_q        <= '0;
            row_q        <= '0;
            win_cnt_q    <= '0;
            win_vld_q    <= 1'b0;
            win_q        <= '0;
            frame_done_q <= 1'b0;
            rdy_en_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            win_cnt_q    <= win_cnt_d;
            win_vld_q    <= win_vld_d;
            win_q        <= win_d;
            frame_done_q <= frame_done_d;
            rdy_en_q     <= rdy_en_d;
        end
    end

    assign win_vld    = win_vld_q;
    assign win        = win_q;
    assign frame_done = frame_done_q;

`ifdef CNN_WIN_IDX_EN
    logic [4:0] win_row_q;
    logic [4:0] win_row_d;
    logic [4:0] win_col_q;
    logic [4:0] win_col_d;

    always_comb begin
        win_row_d = win_row_q;
        win_col_d = win_col_q;
        if (emit) begin
            win_row_d = row_q - 5'd2;
            win_col_d = col_q - 5'd2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_row_q <= '0;
            win_col_q <= '0;
        end else begin
            win_row_q <= win_row_d;
            win_col_q <= win_col_d;
        end
    end

    assign win_row = win_row_q;
    assign win_col = win_col_q;
`endif

endmodule

// File: tb/tb_cnn_window_gen.sv
// Bench for cnn_window_gen: random frames against an image-array window model.
// Define CNN_WIN_IDX_EN to also cover the window coordinate outputs.
module tb_cnn_window_gen;

    localparam int W  = 28;
    localparam int H  = 28;
    localparam int OW = 26;
    localparam int NW = 676;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic       pix_vld;
    logic       pix;
    logic       pix_rdy;
    logic       win_vld;
    logic [8:0] win;
    logic       win_rdy;
    logic       frame_done;
`ifdef CNN_WIN_IDX_EN
    logic [4:0] win_row;
    logic [4:0] win_col;
`endif

    cnn_window_gen dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .pix_vld   (pix_vld),
        .pix       (pix),
        .pix_rdy   (pix_rdy),
        .win_vld   (win_vld),
        .win       (win),
        .win_rdy   (win_rdy),
        .frame_done(frame_done)
`ifdef CNN_WIN_IDX_EN
        ,
        .win_row   (win_row),
        .win_col   (win_col)
`endif
    );

    always #5 clk = ~clk;

    bit         img [0:H-1][0:W-1];
    logic [8:0] got_q [$];
    int         got_r [$];
    int         got_c [$];
    int n_cmp = 0;
    int n_bad = 0;
    int fd_count;
    int fd_iter;
    int last_iter;
    int stall_bad;
    int stall_cycles;
    int timeout;

    // Window with top-left (tr,tc): bit 3*i+j is pixel (tr+i, tc+j).
    function automatic logic [8:0] model_win(input int tr, input int tc);
        logic [8:0] w;
        w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[3*i+j] = img[tr+i][tc+j];
        return w;
    endfunction

    task automatic rand_img();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = 1'($urandom_range(1));
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr = 1'b1;
        pix_vld = 1'b0;
        win_rdy = 1'b0;
        @(negedge clk);
        clr = 1'b0;
    endtask

    // Drives img in raster order, records accepted windows; no checking here.
    task automatic run_stream(input int vld_pct, input int rdy_pct,
                              input int limit, input int stall_at);
        int sent = 0;
        int it = 0;
        int post = 0;
        int stall_left = 0;
        bit stall_done = 0;
        bit fd_seen = 0;
        logic [8:0] stall_win = '0;
        got_q.delete();
        got_r.delete();
        got_c.delete();
        fd_count = 0;
        fd_iter = -1;
        last_iter = -1;
        stall_bad = 0;
        stall_cycles = 0;
        timeout = 0;
        forever begin
            @(negedge clk);
            if (sent < limit && $urandom_range(99) < vld_pct) begin
                pix_vld = 1'b1;
                pix = img[sent / W][sent % W];
            end else begin
                pix_vld = 1'b0;
                pix = 1'($urandom);
            end
            if (stall_left == 0 && !stall_done && stall_at >= 0
                && got_q.size() == stall_at && win_vld === 1'b1) begin
                stall_left = 10;
                stall_win = win;
                stall_done = 1;
            end
            if (stall_left > 0) win_rdy = 1'b0;
            else win_rdy = ($urandom_range(99) < rdy_pct);
            #1;
            if (stall_left > 0) begin
                stall_left--;
                stall_cycles++;
                if (pix_rdy !== 1'b0 || win_vld !== 1'b1 || win !== stall_win)
                    stall_bad++;
            end
            if (frame_done === 1'b1) begin
                fd_count++;
                fd_iter = it;
                fd_seen = 1;
            end
            if (win_vld === 1'b1 && win_rdy) begin
                got_q.push_back(win);
`ifdef CNN_WIN_IDX_EN
                got_r.push_back(int'(win_row));
                got_c.push_back(int'(win_col));
`endif
                if (got_q.size() == NW) last_iter = it;
            end
            if (pix_vld && pix_rdy === 1'b1) sent++;
            it++;
            if (limit < H*W && sent == limit) break;
            if (fd_seen) post++;
            if (post > 3) break;
            if (it >= 20000) begin
                timeout = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clr = 1'b0;
        pix_vld = 1'b0;
        pix = 1'b0;
        win_rdy = 1'b0;
        #1;
        n_cmp++;
        if (pix_rdy !== 1'b0 || win_vld !== 1'b0 || win !== 9'd0
            || frame_done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: rdy=%b vld=%b win=%b fd=%b, want 0 0 0 0",
                     pix_rdy, win_vld, win, frame_done);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (pix_rdy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_first_cycle_rdy: got %b, want 0", pix_rdy);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (pix_rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_rdy_after: got %b, want 1", pix_rdy);
        end
    endtask

    task automatic test_full_frame();
        rand_img();
        pulse_clr();
        run_stream(100, 100, H*W, -1);
        n_cmp++;
        if (timeout != 0 || got_q.size() != NW) begin
            n_bad++;
            $display("FAIL full_count: got %0d windows (timeout=%0d), want %0d",
                     got_q.size(), timeout, NW);
        end
        for (int k = 0; k < got_q.size() && k < NW; k++) begin
            n_cmp++;
            if (got_q[k] !== model_win(k / OW, k % OW)) begin
                n_bad++;
                $display("FAIL full_win[%0d]: got %b, want %b",
                         k, got_q[k], model_win(k / OW, k % OW));
            end
        end
        n_cmp++;
        if (fd_count != 1 || fd_iter != last_iter + 1) begin
            n_bad++;
            $display("FAIL full_frame_done: pulses=%0d at %0d, want 1 at %0d",
                     fd_count, fd_iter, last_iter + 1);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            pix_vld = 1'b1;
            pix = 1'b1;
            win_rdy = 1'b1;
            #1;
            n_cmp++;
            if (pix_rdy !== 1'b0 || win_vld !== 1'b0 || frame_done !== 1'b0) begin
                n_bad++;
                $display("FAIL done_ignore: rdy=%b vld=%b fd=%b, want 0 0 0",
                         pix_rdy, win_vld, frame_done);
            end
        end
        pix_vld = 1'b0;
    endtask

    task automatic test_random_handshake();
        rand_img();
        pulse_clr();
        run_stream(70, 60, H*W, -1);
        n_cmp++;
        if (timeout != 0 || got_q.size() != NW) begin
            n_bad++;
            $display("FAIL hs_count: got %0d windows (timeout=%0d), want %0d",
                     got_q.size(), timeout, NW);
        end
        for (int k = 0; k < got_q.size() && k < NW; k++) begin
            n_cmp++;
            if (got_q[k] !== model_win(k / OW, k % OW)) begin
                n_bad++;
                $display("FAIL hs_win[%0d]: got %b, want %b",
                         k, got_q[k], model_win(k / OW, k % OW));
            end
        end
        n_cmp++;
        if (fd_count != 1 || fd_iter != last_iter + 1) begin
            n_bad++;
            $display("FAIL hs_frame_done: pulses=%0d at %0d, want 1 at %0d",
                     fd_count, fd_iter, last_iter + 1);
        end
    endtask

    task automatic test_single_pixel();
        int nz = 0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = 1'b0;
        img[5][7] = 1'b1;
        pulse_clr();
        run_stream(100, 100, H*W, -1);
        n_cmp++;
        if (got_q.size() != NW) begin
            n_bad++;
            $display("FAIL single_count: got %0d windows, want %0d",
                     got_q.size(), NW);
        end
        for (int k = 0; k < got_q.size() && k < NW; k++) begin
            if (got_q[k] != 9'd0) nz++;
            n_cmp++;
            if (got_q[k] !== model_win(k / OW, k % OW)) begin
                n_bad++;
                $display("FAIL single_win[%0d]: got %b, want %b",
                         k, got_q[k], model_win(k / OW, k % OW));
            end
        end
        n_cmp++;
        if (nz != 9) begin
            n_bad++;
            $display("FAIL single_nonzero: got %0d windows set, want 9", nz);
        end
        n_cmp++;
        if (got_q[5*OW+7] !== 9'b000000001) begin
            n_bad++;
            $display("FAIL single_tl_5_7: got %b, want 000000001", got_q[5*OW+7]);
        end
        n_cmp++;
        if (got_q[3*OW+5] !== 9'b100000000) begin
            n_bad++;
            $display("FAIL single_tl_3_5: got %b, want 100000000", got_q[3*OW+5]);
        end
    endtask

    task automatic test_backpressure();
        rand_img();
        pulse_clr();
        run_stream(100, 100, H*W, 300);
        n_cmp++;
        if (stall_cycles != 10 || stall_bad != 0) begin
            n_bad++;
            $display("FAIL bp_stall: cycles=%0d bad=%0d, want 10 and 0",
                     stall_cycles, stall_bad);
        end
        n_cmp++;
        if (got_q.size() != NW) begin
            n_bad++;
            $display("FAIL bp_count: got %0d windows, want %0d", got_q.size(), NW);
        end
        for (int k = 0; k < got_q.size() && k < NW; k++) begin
            n_cmp++;
            if (got_q[k] !== model_win(k / OW, k % OW)) begin
                n_bad++;
                $display("FAIL bp_win[%0d]: got %b, want %b",
                         k, got_q[k], model_win(k / OW, k % OW));
            end
        end
    endtask

    task automatic test_clr_restart();
        rand_img();
        pulse_clr();
        run_stream(100, 100, 300, -1);
        @(negedge clk);
        pix_vld = 1'b0;
        win_rdy = 1'b0;
        #1;
        n_cmp++;
        if (win_vld !== 1'b1) begin
            n_bad++;
            $display("FAIL clr_pending: win_vld=%b, want 1", win_vld);
        end
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        #1;
        n_cmp++;
        if (win_vld !== 1'b0 || pix_rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL clr_state: vld=%b rdy=%b, want 0 1", win_vld, pix_rdy);
        end
        rand_img();
        run_stream(100, 100, H*W, -1);
        n_cmp++;
        if (got_q.size() != NW || fd_count != 1) begin
            n_bad++;
            $display("FAIL clr_new_frame: got %0d windows %0d done, want %0d and 1",
                     got_q.size(), fd_count, NW);
        end
        for (int k = 0; k < got_q.size() && k < NW; k++) begin
            n_cmp++;
            if (got_q[k] !== model_win(k / OW, k % OW)) begin
                n_bad++;
                $display("FAIL clr_win[%0d]: got %b, want %b",
                         k, got_q[k], model_win(k / OW, k % OW));
            end
        end
    endtask

    task automatic test_rst_mid();
        rand_img();
        pulse_clr();
        run_stream(100, 100, 400, -1);
        @(negedge clk);
        pix_vld = 1'b0;
        win_rdy = 1'b0;
        #1;
        n_cmp++;
        if (win_vld !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_pending: win_vld=%b, want 1", win_vld);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (win_vld !== 1'b0 || frame_done !== 1'b0 || pix_rdy !== 1'b0
            || win !== 9'd0) begin
            n_bad++;
            $display("FAIL rst_async: vld=%b fd=%b rdy=%b win=%b, want 0 0 0 0",
                     win_vld, frame_done, pix_rdy, win);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        n_cmp++;
        if (pix_rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_rdy_back: got %b, want 1", pix_rdy);
        end
        rand_img();
        run_stream(100, 100, H*W, -1);
        n_cmp++;
        if (got_q.size() != NW || fd_count != 1) begin
            n_bad++;
            $display("FAIL rst_new_frame: got %0d windows %0d done, want %0d and 1",
                     got_q.size(), fd_count, NW);
        end
        for (int k = 0; k < got_q.size() && k < NW; k++) begin
            n_cmp++;
            if (got_q[k] !== model_win(k / OW, k % OW)) begin
                n_bad++;
                $display("FAIL rst_win[%0d]: got %b, want %b",
                         k, got_q[k], model_win(k / OW, k % OW));
            end
        end
    endtask

`ifdef CNN_WIN_IDX_EN
    task automatic test_idx();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = ((r + c) % 2 == 0);
        pulse_clr();
        run_stream(100, 80, H*W, -1);
        n_cmp++;
        if (got_q.size() != NW) begin
            n_bad++;
            $display("FAIL idx_count: got %0d windows, want %0d", got_q.size(), NW);
        end
        for (int k = 0; k < got_q.size() && k < NW; k++) begin
            n_cmp++;
            if (got_r[k] != k / OW || got_c[k] != k % OW) begin
                n_bad++;
                $display("FAIL idx_pos[%0d]: got (%0d,%0d), want (%0d,%0d)",
                         k, got_r[k], got_c[k], k / OW, k % OW);
            end
            if ((k / OW + k % OW) % 2 == 0) begin
                n_cmp++;
                if (got_q[k] !== 9'b101010101) begin
                    n_bad++;
                    $display("FAIL idx_even_win[%0d]: got %b, want 101010101",
                             k, got_q[k]);
                end
            end
        end
    endtask
`endif

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_full_frame();
        test_random_handshake();
        test_single_pixel();
        test_backpressure();
        test_clr_restart();
        test_rst_mid();
`ifdef CNN_WIN_IDX_EN
        test_idx();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
